// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the default register-file geometry, the controller state encoding and
// a helper that sizes requester-index fields.
package regfile_write_arbiter_pkg;

  localparam int unsigned RF_ADDR_W  = 5;
  localparam int unsigned RF_DATA_W  = 32;
  localparam int unsigned GRANT_ID_W = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  // Width of an index into n requesters (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request found searching upward from i_ptr and
// wrapping modulo NUM_REQ.
// Ports:
//   i_req       request vector
//   i_ptr       highest-priority index for this cycle
//   o_grant     one-hot grant (all zero when there is no request)
//   o_grant_idx binary index of the granted requester
module regfile_write_arbiter_rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [31:0]      sum;
  logic [IDX_W-1:0] kidx;
  logic             found;

  // Rotating priority search; the first hit from i_ptr wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    sum         = '0;
    kidx        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = 32'(i_ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      kidx = IDX_W'(sum);
      if (!found && i_req[kidx]) begin
        found         = 1'b1;
        o_grant[kidx] = 1'b1;
        o_grant_idx   = kidx;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register-file write port.
// After reset it clears every register once, then shares the port between
// NUM_REQ writeback sources using round-robin arbitration and valid/ready.
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_req_valid          per-requester write request
//   i_req_addr           packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   i_req_data           packed data, requester k at [k*DATA_W +: DATA_W]
//   o_req_ready          one-hot grant (combinational)
//   o_rf_we/waddr/wdata  registered register-file write strobe
//   o_init_done          high once the clear sweep has finished
//   o_grant_id           requester accepted in the previous cycle
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_rf_we,
  output logic [ADDR_W-1:0]         o_rf_waddr,
  output logic [DATA_W-1:0]         o_rf_wdata,
  output logic                      o_init_done,
  output logic [GRANT_ID_W-1:0]     o_grant_id
);

  localparam int unsigned IDX_W    = idx_width(NUM_REQ);
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  state_e             state;
  logic [ADDR_W-1:0]  cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  regfile_write_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_req      (i_req_valid),
    .i_ptr      (rr_ptr),
    .o_grant    (grant),
    .o_grant_idx(grant_idx)
  );

  // Grants are only offered in ARB and never while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    accept      = 1'b0;
    sel_addr    = i_req_addr[grant_idx*ADDR_W +: ADDR_W];
    sel_data    = i_req_data[grant_idx*DATA_W +: DATA_W];
    if (state == ST_ARB && i_rst_n) begin
      o_req_ready = grant;
      accept      = |grant;
    end
  end

  // Controller: clear sweep, then registered writeback of the granted request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_INIT;
      cnt         <= '0;
      rr_ptr      <= '0;
      o_rf_we     <= 1'b0;
      o_rf_waddr  <= '0;
      o_rf_wdata  <= '0;
      o_init_done <= 1'b0;
      o_grant_id  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          o_rf_we    <= 1'b1;
          o_rf_waddr <= cnt;
          o_rf_wdata <= '0;
          cnt        <= cnt + 1'b1;
          if (cnt == ADDR_W'(NUM_REGS - 1)) begin
            state       <= ST_ARB;
            o_init_done <= 1'b1;
          end
        end
        ST_ARB: begin
          if (accept) begin
            // Register zero is hard-wired: accept the request but drop the strobe.
            o_rf_we    <= (sel_addr != '0);
            o_rf_waddr <= sel_addr;
            o_rf_wdata <= sel_data;
            o_grant_id <= GRANT_ID_W'(grant_idx);
            rr_ptr     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end else begin
            o_rf_we <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: clear sweep, arbitration vectors,
// zero-register writes, held requests and reset during sweep and operation.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  valid;
  logic [14:0] addr;
  logic [95:0] data;
  logic [2:0]  ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        init_done;
  logic [2:0]  grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic        we;
    logic        chk_wr;
    logic        chk_gid;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  gid;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[15];

  regfile_write_arbiter #(
    .NUM_REQ(3),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(valid),
    .i_req_addr (addr),
    .i_req_data (data),
    .o_req_ready(ready),
    .o_rf_we    (we),
    .o_rf_waddr (waddr),
    .o_rf_wdata (wdata),
    .o_init_done(init_done),
    .o_grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] er);
    vec_t r;
    r.valid     = v;
    r.addr      = {a2, a1, a0};
    r.data      = {d2, d1, d0};
    r.exp_ready = er;
    return r;
  endfunction

  // Compare the registered write against the oldest scoreboard entry.
  task automatic pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got we=%0b expected an entry", name, we);
    end else begin
      e = sbq.pop_front();
      chk({name, " we"}, 32'(we), 32'(e.we));
      if (e.chk_wr) begin
        chk({name, " waddr"}, 32'(waddr), 32'(e.waddr));
        chk({name, " wdata"}, wdata, e.wdata);
      end
      if (e.chk_gid) chk({name, " grant_id"}, 32'(grant_id), 32'(e.gid));
    end
  endtask

  // One ARB cycle: drive, check ready, push expectation, clock, check output.
  task automatic step(input vec_t v, input string name);
    exp_t       e;
    int         g;
    logic [4:0] a;
    valid = v.valid;
    addr  = v.addr;
    data  = v.data;
    #1;
    chk({name, " ready"}, 32'(ready), 32'(v.exp_ready));
    e.we = 1'b0; e.chk_wr = 1'b0; e.chk_gid = 1'b0;
    e.waddr = '0; e.wdata = '0; e.gid = '0;
    if (v.exp_ready != 3'b000) begin
      g = 0;
      for (int i = 0; i < 3; i++) if (v.exp_ready[i]) g = i;
      a         = v.addr[g*5 +: 5];
      e.we      = (a != 5'd0);
      e.chk_wr  = (a != 5'd0);
      e.chk_gid = 1'b1;
      e.waddr   = a;
      e.wdata   = v.data[g*32 +: 32];
      e.gid     = 3'(g);
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    pop_check(name);
  endtask

  // Full 32-cycle clear sweep starting at the first edge with reset released.
  task automatic sweep(input logic [2:0] exp_ready_last, input string name);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      chk({name, " we"}, 32'(we), 32'd1);
      chk({name, " waddr"}, 32'(waddr), 32'(k));
      chk({name, " wdata"}, wdata, 32'd0);
      if (k < 31) begin
        chk({name, " ready"}, 32'(ready), 32'd0);
        chk({name, " init_done"}, 32'(init_done), 32'd0);
      end else begin
        chk({name, " init_done end"}, 32'(init_done), 32'd1);
        chk({name, " ready end"}, 32'(ready), 32'(exp_ready_last));
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b001);
    vecs[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b010);
    vecs[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b100);
    vecs[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b001);
    vecs[4]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
    vecs[5]  = mk(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010);
    vecs[6]  = mk(3'b001, 5'd0, 5'd0, 5'd0, 32'h00001234, 32'h0, 32'h0, 3'b001);
    vecs[7]  = mk(3'b101, 5'd6, 5'd0, 5'd8, 32'h66666666, 32'h0, 32'h88888888, 3'b100);
    vecs[8]  = mk(3'b101, 5'd6, 5'd0, 5'd8, 32'h66666666, 32'h0, 32'h88888888, 3'b001);
    vecs[9]  = mk(3'b011, 5'd10, 5'd11, 5'd0, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 3'b010);
    vecs[10] = mk(3'b011, 5'd10, 5'd11, 5'd0, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 3'b001);
    vecs[11] = mk(3'b110, 5'd0, 5'd13, 5'd14, 32'h0, 32'h13131313, 32'h14141414, 3'b010);
    vecs[12] = mk(3'b001, 5'd31, 5'd0, 5'd0, 32'hFFFF0001, 32'h0, 32'h0, 3'b001);
    vecs[13] = mk(3'b010, 5'd0, 5'd12, 5'd0, 32'h0, 32'hAAAA0000, 32'h0, 3'b010);
    vecs[14] = mk(3'b100, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'hBBBB0000, 3'b100);

    // Reset with requester 2 already waiting.
    rst_n = 1'b0;
    valid = 3'b100;
    addr  = {5'd7, 10'd0};
    data  = {32'hCAFE0002, 64'd0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst we", 32'(we), 32'd0);
    chk("rst waddr", 32'(waddr), 32'd0);
    chk("rst wdata", wdata, 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    chk("rst ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    sweep(3'b100, "sweep1");
    step(mk(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hCAFE0002, 3'b100), "held_req2");
    step(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000), "held_once");

    for (int i = 0; i < 15; i++) step(vecs[i], $sformatf("vec%0d", i));
    step(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000), "idle_after");

    // Reset in the same cycle as an accept: the write must not appear.
    valid = 3'b001;
    addr  = {10'd0, 5'd4};
    data  = {64'd0, 32'h00000077};
    #1;
    chk("arb_rst ready before", 32'(ready), 32'b001);
    rst_n = 1'b0;
    #1;
    chk("arb_rst ready in reset", 32'(ready), 32'd0);
    @(posedge clk); #1;
    chk("arb_rst we", 32'(we), 32'd0);
    chk("arb_rst waddr", 32'(waddr), 32'd0);
    chk("arb_rst init_done", 32'(init_done), 32'd0);
    chk("arb_rst grant_id", 32'(grant_id), 32'd0);
    valid = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset at cycle 10 of the sweep; the sweep restarts from address 0.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("part_sweep waddr", 32'(waddr), 32'(k));
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_sweep_rst we", 32'(we), 32'd0);
    chk("mid_sweep_rst waddr", 32'(waddr), 32'd0);
    rst_n = 1'b1;
    sweep(3'b000, "sweep2");
    step(mk(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0BADF00D, 32'h0, 3'b010), "post_rst");
    step(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000), "post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
